// File: rtl/sram_arb_pkg.sv
// Shared encodings for the single-port SRAM arbiter (state machine and requester ids).
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/sram_arb_select.sv
// Winner select for the SRAM arbiter: fixed MEM priority with an IF starvation guard,
// or round-robin when SRAM_ARB_ROUND_ROBIN_EN is defined.
module sram_arb_select
  import sram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic mem_req,
  input  logic grant,
  output logic win_id_c
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the port that was not granted last time wins.
  always_comb begin
    win_id_c = REQ_IF;
    if (if_req && mem_req) begin
      win_id_c = ~last_grant;
    end else if (mem_req) begin
      win_id_c = REQ_MEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_IF;
    end else if (grant) begin
      last_grant <= win_id_c;
    end
  end
`else
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // MEM wins unless IF has already lost LIMIT arbitrations in a row.
  always_comb begin
    win_id_c = REQ_IF;
    if (mem_req && !(if_req && (starve_cnt >= LIMIT))) begin
      win_id_c = REQ_MEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (if_req && (win_id_c == REQ_MEM)) begin
        if (starve_cnt < LIMIT) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the IF and MEM cache refill ports.
// Optional build macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned SRAM_DATA_BIT = 128,
  parameter int unsigned SRAM_ADDR_BIT = 12,
  parameter int unsigned SRAM_RD_LAT   = 1,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_sys_i,
  input  logic                     if_req_i,
  input  logic                     if_we_i,
  input  logic [SRAM_ADDR_BIT-1:0] if_addr_i,
  input  logic [SRAM_DATA_BIT-1:0] if_data_i,
  output logic                     if_ack_o,
  output logic [SRAM_DATA_BIT-1:0] if_data_o,
  input  logic                     mem_req_i,
  input  logic                     mem_we_i,
  input  logic [SRAM_ADDR_BIT-1:0] mem_addr_i,
  input  logic [SRAM_DATA_BIT-1:0] mem_data_i,
  output logic                     mem_ack_o,
  output logic [SRAM_DATA_BIT-1:0] mem_data_o,
  output logic                     sram_ena_o,
  output logic                     sram_wea_o,
  output logic [SRAM_ADDR_BIT-1:0] sram_addr_o,
  output logic [SRAM_DATA_BIT-1:0] sram_data_o,
  input  logic [SRAM_DATA_BIT-1:0] sram_data_i,
  output logic                     busy_o
);

  localparam int unsigned LAT_W = 3;

  arb_state_e       state;
  logic             win_id;
  logic [LAT_W-1:0] lat_cnt;
  logic             win_id_c;
  logic             grant_c;

  assign grant_c = (state == IDLE) && (if_req_i || mem_req_i);

  sram_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk     (clk_sys_i),
    .rst     (rst_sys_i),
    .if_req  (if_req_i),
    .mem_req (mem_req_i),
    .grant   (grant_c),
    .win_id_c(win_id_c)
  );

  // Access sequencer; sram_wea_o doubles as the latched write flag during ACCESS.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state       <= IDLE;
      win_id      <= REQ_IF;
      lat_cnt     <= '0;
      sram_ena_o  <= 1'b0;
      sram_wea_o  <= 1'b0;
      sram_addr_o <= '0;
      sram_data_o <= '0;
      if_ack_o    <= 1'b0;
      mem_ack_o   <= 1'b0;
      if_data_o   <= '0;
      mem_data_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_c) begin
            win_id     <= win_id_c;
            sram_ena_o <= 1'b1;
            if (win_id_c == REQ_MEM) begin
              sram_wea_o  <= mem_we_i;
              sram_addr_o <= mem_addr_i;
              sram_data_o <= mem_data_i;
            end else begin
              sram_wea_o  <= if_we_i;
              sram_addr_o <= if_addr_i;
              sram_data_o <= if_data_i;
            end
            busy_o <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          sram_ena_o <= 1'b0;
          sram_wea_o <= 1'b0;
          if (sram_wea_o) begin
            if_ack_o  <= (win_id == REQ_IF);
            mem_ack_o <= (win_id == REQ_MEM);
            state     <= DONE;
          end else begin
            lat_cnt <= LAT_W'(SRAM_RD_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_W'(1)) begin
            if (win_id == REQ_MEM) begin
              mem_data_o <= sram_data_i;
              mem_ack_o  <= 1'b1;
            end else begin
              if_data_o <= sram_data_i;
              if_ack_o  <= 1'b1;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
